// File: rtl/fetch_ctrl_pkg.sv
// Shared types and default widths for the fetch stage, the IR and TopLevel.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fetch_state_t;

   localparam int PC_W_DEF  = 10;
   localparam int OFF_W_DEF = 8;
   localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Run-control and decoder redirect bundle between the decoder side and fetch_ctrl.
interface fetch_ctrl_if
   import fetch_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int OFF_W = OFF_W_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   logic             start;
   logic             halt;
   logic             jump;
   logic             br_taken;
   logic [PC_W-1:0]  target;
   logic [OFF_W-1:0] offset;
   logic [PC_W-1:0]  prog_ctr;
   logic             running;
   logic             ack;
   logic [CNT_W-1:0] cycle_ct;

   modport master (
      output start, halt, jump, br_taken, target, offset,
      input  prog_ctr, running, ack, cycle_ct
   );

   modport slave (
      input  start, halt, jump, br_taken, target, offset,
      output prog_ctr, running, ack, cycle_ct
   );
endinterface

// File: rtl/fetch_ctrl_pc_next.sv
// Combinational next-PC select: halt holds, jump is absolute, branch is PC-relative.
module pc_next #(
   parameter int PC_W  = 10,
   parameter int OFF_W = 8
) (
   input  logic [PC_W-1:0]  prog_ctr,
   input  logic             halt,
   input  logic             jump,
   input  logic             br_taken,
   input  logic [PC_W-1:0]  target,
   input  logic [OFF_W-1:0] offset,
   output logic [PC_W-1:0]  next_pc
);
   logic [PC_W-1:0] offset_ext;

   // Sign-extend (or truncate) the offset so the add wraps modulo 2**PC_W.
   generate
      for (genvar gi = 0; gi < PC_W; gi++) begin : g_ext
         if (gi < OFF_W) begin : g_bit
            assign offset_ext[gi] = offset[gi];
         end else begin : g_sign
            assign offset_ext[gi] = offset[OFF_W-1];
         end
      end
   endgenerate

   always_comb begin
      next_pc = prog_ctr + PC_W'(1);
      if (halt) begin
         next_pc = prog_ctr;
      end else if (jump) begin
         next_pc = target;
      end else if (br_taken) begin
         next_pc = prog_ctr + offset_ext;
      end
   end
endmodule

// File: rtl/fetch_ctrl.sv
// Program counter and IDLE/RUN/DONE run control with a saturating RUN-cycle counter.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int OFF_W = OFF_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   fetch_ctrl_if.slave  bus
);
   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_RUN  = RUN;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]       state_reg, state_next;
   logic [PC_W-1:0]  prog_ctr_reg, prog_ctr_next;
   logic [CNT_W-1:0] cycle_ct_reg, cycle_ct_next;
   logic             running_reg, ack_reg;
   logic [PC_W-1:0]  redirect_pc;
   logic [CNT_W-1:0] cycle_ct_inc;

   pc_next #(
      .PC_W  (PC_W),
      .OFF_W (OFF_W)
   ) u_pc_next (
      .prog_ctr (prog_ctr_reg),
      .halt     (bus.halt),
      .jump     (bus.jump),
      .br_taken (bus.br_taken),
      .target   (bus.target),
      .offset   (bus.offset),
      .next_pc  (redirect_pc)
   );

   assign cycle_ct_inc = (cycle_ct_reg == {CNT_W{1'b1}}) ? cycle_ct_reg
                                                          : cycle_ct_reg + CNT_W'(1);

   // Start dominates every state; it also beats a simultaneous halt in RUN.
   always_comb begin
      state_next    = state_reg;
      prog_ctr_next = prog_ctr_reg;
      cycle_ct_next = cycle_ct_reg;
      case (state_reg)
         S_IDLE: begin
            prog_ctr_next = '0;
            cycle_ct_next = '0;
            if (!bus.start) state_next = S_RUN;
         end
         S_RUN: begin
            if (bus.start) begin
               state_next    = S_IDLE;
               prog_ctr_next = '0;
               cycle_ct_next = '0;
            end else begin
               prog_ctr_next = redirect_pc;
               cycle_ct_next = cycle_ct_inc;
               if (bus.halt) state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.start) begin
               state_next    = S_IDLE;
               prog_ctr_next = '0;
               cycle_ct_next = '0;
            end
         end
         default: begin
            state_next    = S_IDLE;
            prog_ctr_next = '0;
            cycle_ct_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         prog_ctr_reg <= '0;
         cycle_ct_reg <= '0;
         running_reg  <= 1'b0;
         ack_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         prog_ctr_reg <= prog_ctr_next;
         cycle_ct_reg <= cycle_ct_next;
         running_reg  <= (state_next == S_RUN);
         ack_reg      <= (state_next == S_DONE);
      end
   end

   assign bus.prog_ctr = prog_ctr_reg;
   assign bus.running  = running_reg;
   assign bus.ack      = ack_reg;
   assign bus.cycle_ct = cycle_ct_reg;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: default widths plus a 4-bit counter instance.
module tb_fetch_ctrl;
   logic clk;
   logic rst;
   logic rst4;
   int   checks;
   int   errors;

   fetch_ctrl_if #(.PC_W(10), .OFF_W(8), .CNT_W(16)) bus  ();
   fetch_ctrl_if #(.PC_W(10), .OFF_W(8), .CNT_W(4))  bus4 ();

   fetch_ctrl #(.PC_W(10), .OFF_W(8), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   fetch_ctrl #(.PC_W(10), .OFF_W(8), .CNT_W(4)) dut4 (
      .clk (clk),
      .rst (rst4),
      .bus (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
      $display("check %-14s observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic run, input logic ak,
                             input logic [9:0] pc, input logic [15:0] cnt);
      check({tag, ".run"}, 32'(bus.running), 32'(run));
      check({tag, ".ack"}, 32'(bus.ack), 32'(ak));
      check({tag, ".pc"}, 32'(bus.prog_ctr), 32'(pc));
      check({tag, ".cnt"}, 32'(bus.cycle_ct), 32'(cnt));
   endtask

   task automatic set_dec(input logic h, input logic j, input logic b,
                          input logic [9:0] t, input logic [7:0] o);
      bus.halt = h; bus.jump = j; bus.br_taken = b; bus.target = t; bus.offset = o;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0; rst4 = 1'b1;
      bus.start = 1'b0;
      set_dec(0, 0, 0, 10'h000, 8'h00);
      bus4.start = 1'b0; bus4.halt = 1'b0; bus4.jump = 1'b0; bus4.br_taken = 1'b0;
      bus4.target = '0; bus4.offset = '0;

      // 1: reset state, then sequential fetch
      #1 rst = 1'b1;
      #1 expect_out("rst", 0, 0, 10'h000, 16'd0);
      step(); rst = 1'b0;
      step(); expect_out("t1.enter", 1, 0, 10'h000, 16'd0);
      step(); expect_out("t1.pc1", 1, 0, 10'h001, 16'd1);
      step(); expect_out("t1.pc2", 1, 0, 10'h002, 16'd2);
      step(); expect_out("t1.pc3", 1, 0, 10'h003, 16'd3);

      // 2: Start held for 5 cycles aborts and holds IDLE
      bus.start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(); expect_out("t2.idle", 0, 0, 10'h000, 16'd0);
      end
      bus.start = 1'b0;
      step(); expect_out("t2.enter", 1, 0, 10'h000, 16'd0);
      step(); expect_out("t2.pc1", 1, 0, 10'h001, 16'd1);
      step(); step(); step(); step();
      expect_out("t2.pc5", 1, 0, 10'h005, 16'd5);

      // 3: absolute jump, backward branch, jump beats branch
      set_dec(0, 1, 0, 10'h040, 8'h00);
      step(); expect_out("t3.jump", 1, 0, 10'h040, 16'd6);
      set_dec(0, 0, 1, 10'h000, 8'hFD);
      step(); expect_out("t3.brneg", 1, 0, 10'h03D, 16'd7);
      set_dec(0, 1, 1, 10'h003, 8'h10);
      step(); expect_out("t3.jmpbr", 1, 0, 10'h003, 16'd8);

      // 4: branch wraps below zero, increment wraps past max
      set_dec(0, 0, 1, 10'h000, 8'hF8);
      step(); expect_out("t4.brwrap", 1, 0, 10'h3FB, 16'd9);
      set_dec(0, 1, 0, 10'h3FF, 8'h00);
      step(); expect_out("t4.max", 1, 0, 10'h3FF, 16'd10);
      set_dec(0, 0, 0, 10'h000, 8'h00);
      step(); expect_out("t4.incwrap", 1, 0, 10'h000, 16'd11);
      set_dec(0, 0, 1, 10'h000, 8'h7F);
      step(); expect_out("t4.brpos", 1, 0, 10'h07F, 16'd12);

      // 5: halt, DONE hold, re-arm, rerun
      set_dec(0, 1, 0, 10'h012, 8'h00);
      step(); expect_out("t5.pc12", 1, 0, 10'h012, 16'd13);
      set_dec(1, 0, 0, 10'h000, 8'h00);
      step(); expect_out("t5.halt", 0, 1, 10'h012, 16'd14);
      set_dec(1, 1, 0, 10'h155, 8'h00);
      step(); expect_out("t5.done", 0, 1, 10'h012, 16'd14);
      set_dec(0, 0, 0, 10'h000, 8'h00);
      bus.start = 1'b1;
      step(); expect_out("t5.rearm", 0, 0, 10'h000, 16'd0);
      bus.start = 1'b0;
      step(); expect_out("t5.rerun", 1, 0, 10'h000, 16'd0);
      step(); expect_out("t5.rerun1", 1, 0, 10'h001, 16'd1);

      // 6a: asynchronous reset mid-RUN, between clock edges
      set_dec(0, 1, 0, 10'h020, 8'h00);
      step(); expect_out("t6.pc20", 1, 0, 10'h020, 16'd2);
      set_dec(0, 0, 0, 10'h000, 8'h00);
      #2 rst = 1'b1;
      #1 expect_out("t6.async", 0, 0, 10'h000, 16'd0);
      #1 rst = 1'b0;
      step(); expect_out("t6.enter", 1, 0, 10'h000, 16'd0);
      step(); expect_out("t6.pc1", 1, 0, 10'h001, 16'd1);

      // 6b: Start beats Halt; Ack never rises
      set_dec(1, 0, 0, 10'h000, 8'h00);
      bus.start = 1'b1;
      step(); expect_out("t6.stHalt", 0, 0, 10'h000, 16'd0);
      set_dec(0, 0, 0, 10'h000, 8'h00);
      bus.start = 1'b0;
      step(); expect_out("t6.after", 1, 0, 10'h000, 16'd0);

      // 6c: 4-bit counter saturates at 15
      rst4 = 1'b0;
      step();
      check("t6.cnt4.enter", 32'(bus4.cycle_ct), 32'd0);
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 14) check("t6.cnt4.14", 32'(bus4.cycle_ct), 32'd14);
         if (i == 15) check("t6.cnt4.15", 32'(bus4.cycle_ct), 32'd15);
      end
      check("t6.cnt4.sat", 32'(bus4.cycle_ct), 32'd15);
      check("t6.cnt4.pc", 32'(bus4.prog_ctr), 32'd20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
